// File: rtl/lz77_decoder.sv
// lz77_decoder: expands (position, length, literal) tokens into a symbol stream using a circular history buffer.
module lz77_decoder #(
    parameter int DATA_WIDTH           = 8,
    parameter int DICTIONARY_DEPTH     = 2048,
    parameter int DICTIONARY_DEPTH_LOG = 11,
    parameter int CNT_WIDTH            = 7
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            token_valid,
    output logic                            token_ready,
    input  logic [DICTIONARY_DEPTH_LOG-1:0] match_position,
    input  logic [CNT_WIDTH-1:0]            match_length,
    input  logic [DATA_WIDTH-1:0]           next_symbol,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready
);
    typedef enum logic [1:0] {IDLE, COPY, LITERAL} state_t;
    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] hist [DICTIONARY_DEPTH];
    logic [DICTIONARY_DEPTH_LOG-1:0] wr_ptr, rd_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0] lit;
    logic accept, hs;
    assign token_ready = state == IDLE && rst_n;
    assign out_valid = state != IDLE;
    assign out_data = state == COPY ? hist[rd_ptr] : state == LITERAL ? lit : '0;
    assign accept = token_valid && token_ready;
    assign hs = out_valid && out_ready;
    always_comb begin
        state_nx = state;
        if (state == IDLE && accept)
            state_nx = match_length != '0 ? COPY : LITERAL;
        else if (state == COPY && hs && count == CNT_WIDTH'(1))
            state_nx = LITERAL;
        else if (state == LITERAL && hs)
            state_nx = IDLE;
    end
    // ~match_position == -1 - match_position, so this is wr_ptr - 1 - position modulo depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            lit    <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                rd_ptr <= wr_ptr + ~match_position;
                count  <= match_length;
                lit    <= next_symbol;
            end
            if (hs) begin
                wr_ptr <= wr_ptr + DICTIONARY_DEPTH_LOG'(1);
                if (state == COPY) begin
                    rd_ptr <= rd_ptr + DICTIONARY_DEPTH_LOG'(1);
                    count  <= count - CNT_WIDTH'(1);
                end
            end
        end
    end
    always_ff @(posedge clk)
        if (hs) hist[wr_ptr] <= out_data;
endmodule

// File: tb/tb_lz77_decoder.sv
// tb_lz77_decoder: directed and random tokens checked against a software LZ77 expansion model.
module tb_lz77_decoder;
    logic clk = 0, rst_n = 0, token_valid = 0, token_ready, out_valid, out_ready = 0;
    logic [10:0] match_position = '0;
    logic [6:0] match_length = '0;
    logic [7:0] next_symbol = '0, out_data;
    int errors = 0, checks = 0;
    logic [7:0] mh [2048];
    int wp = 0, n_written = 0;
    bit pat [4] = '{1, 0, 0, 1};

    lz77_decoder dut (
        .clk(clk), .rst_n(rst_n), .token_valid(token_valid), .token_ready(token_ready),
        .match_position(match_position), .match_length(match_length), .next_symbol(next_symbol),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: always ready, 1: random ready, 2: 1,0,0,1 pattern then ready; abort_after>=0 stops early
    task automatic send(input int pos, input int len, input logic [7:0] sym, input int mode, input int abort_after);
        logic [7:0] q[$];
        int base, cyc, got;
        bit r;
        base = (wp - 1 - pos + 4096) % 2048;
        for (int i = 0; i < len; i++) begin
            q.push_back(mh[(base + i) % 2048]);
            mh[wp] = mh[(base + i) % 2048];
            wp = (wp + 1) % 2048;
        end
        q.push_back(sym);
        mh[wp] = sym;
        wp = (wp + 1) % 2048;
        n_written += len + 1;
        check("token_ready_idle", token_ready, 1);
        token_valid = 1;
        match_position = 11'(pos);
        match_length = 7'(len);
        next_symbol = sym;
        @(posedge clk);
        @(negedge clk);
        token_valid = 0;
        got = 0;
        cyc = 0;
        while (got < len + 1 && cyc < 2000) begin
            if (got == abort_after) return;
            r = mode == 0 ? 1'b1 : mode == 2 ? (cyc < 4 ? pat[cyc] : 1'b1) : 1'($urandom_range(0, 1));
            out_ready = r;
            #1;
            check("out_valid_busy", out_valid, 1);
            check("token_ready_busy", token_ready, 0);
            check("out_data", out_data, q[got]);
            if (r) got++;
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
        check("symbol_count", got, len + 1);
        check("out_valid_idle", out_valid, 0);
        check("token_ready_after", token_ready, 1);
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_token_ready", token_ready, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("post_rst_token_ready", token_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        wp = 0;
        n_written = 0;
        @(negedge clk);
    endtask

    initial begin
        int lim, pos, len;
        @(negedge clk);
        do_reset();
        send(0, 0, "a", 0, -1);
        send(0, 0, "b", 0, -1);
        send(0, 0, "c", 0, -1);
        send(2, 3, "d", 0, -1);
        send(0, 0, "x", 0, -1);
        send(0, 5, "y", 0, -1);
        send(3, 6, "e", 2, -1);
        send(0, 127, "m", 1, -1);
        for (int k = 0; k < 40; k++) begin
            lim = n_written < 2048 ? n_written : 2048;
            pos = $urandom_range(0, lim - 1);
            len = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 20);
            send(pos, len, 8'($urandom), 1, -1);
        end
        send(1, 10, "k", 0, 4);
        do_reset();
        send(0, 0, "q", 0, -1);
        send(0, 3, "r", 1, -1);
        do_reset();
        for (int k = 0; k < 2046; k++) send(0, 0, 8'($urandom), 0, -1);
        check("wrap_wp_model", wp, 2046);
        send(3, 6, "z", 0, -1);
        send(0, 0, "w", 0, -1);
        send(2, 4, "v", 1, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lz77_decoder.md
LZ77_DECODER -- requirements
Module: lz77_decoder

Interface
REQ-001 Parameter DATA_WIDTH, default 8: symbol width in bits.
REQ-002 Parameter DICTIONARY_DEPTH, default 2048: history buffer depth in symbols, power of 2.
REQ-003 Parameter DICTIONARY_DEPTH_LOG, default 11: log2(DICTIONARY_DEPTH).
REQ-004 Parameter CNT_WIDTH, default 7: width of the match length field.
REQ-005 clk  input  1: single clock; all state on rising edge.
REQ-006 rst_n  input  1: reset, asynchronous, active-low.
REQ-007 token_valid  input  1: token fields valid.
REQ-008 token_ready  output  1: decoder can accept a token.
REQ-009 match_position  input  DICTIONARY_DEPTH_LOG: back-reference offset; 0 = most recently output symbol.
REQ-010 match_length  input  CNT_WIDTH: number of symbols to copy; 0 = literal only.
REQ-011 next_symbol  input  DATA_WIDTH: literal symbol emitted after the copy.
REQ-012 out_data  output  DATA_WIDTH: decoded symbol.
REQ-013 out_valid  output  1: out_data valid.
REQ-014 out_ready  input  1: downstream accepts out_data.

Function
REQ-015 Token accepted on a rising edge with token_valid=1 and token_ready=1; fields captured into internal registers at that edge.
REQ-016 token_ready SHALL be 1 only in state IDLE.
REQ-017 FSM states: IDLE, COPY, LITERAL.
REQ-018 IDLE -> COPY on acceptance if match_length>0; IDLE -> LITERAL on acceptance if match_length=0.
REQ-019 On acceptance, read pointer = wr_ptr - 1 - match_position, modulo DICTIONARY_DEPTH.
REQ-020 In COPY: out_valid=1, out_data = history[rd_ptr]; on out_valid&out_ready, the symbol is written to history[wr_ptr], wr_ptr and rd_ptr increment modulo DICTIONARY_DEPTH, and the remaining count decrements.
REQ-021 COPY -> LITERAL on the handshake that transfers the last copied symbol (remaining count 1).
REQ-022 In LITERAL: out_valid=1, out_data = captured next_symbol; on handshake the symbol is written to history[wr_ptr], wr_ptr increments, state -> IDLE.
REQ-023 History read is combinational from the array; a symbol written on an edge is readable in the next cycle, so overlapping copies (match_length > match_position+1, e.g. position 0) replicate correctly.
REQ-024 With out_ready=0, out_data, out_valid, pointers, count and state SHALL hold.
REQ-025 Throughput: one symbol per cycle while out_ready=1; a token of length L emits L+1 symbols, first symbol valid the cycle after acceptance.
REQ-026 Token back-to-back: a new token MAY be accepted on the edge following the LITERAL handshake (one IDLE cycle minimum).
REQ-027 Pointer arithmetic is DICTIONARY_DEPTH_LOG bits and wraps naturally at DICTIONARY_DEPTH.
REQ-028 Reads of history locations never written return undefined data; producing such references is an upstream error and is not detected.
REQ-029 Copy count register is CNT_WIDTH bits; match_length up to 2^CNT_WIDTH-1 SHALL be supported.

Reset
REQ-030 On rst_n=0, asynchronously: state=IDLE, wr_ptr=0, rd_ptr=0, count=0, out_valid=0, out_data=0, token_ready deasserts until the reset is released, then =1 in IDLE.
REQ-031 History array contents are not reset.
REQ-032 Reset asserted mid-token SHALL abort the token; no further symbols of it are emitted after release.

Verification
REQ-033 Literals: tokens (0,0,'a'),(0,0,'b'),(0,0,'c'), out_ready=1 -> out_data sequence 'a','b','c', each one cycle after acceptance.
REQ-034 Back-reference: after "abc", token (pos=2,len=3,'d') -> "abcd" emitted, total stream "abcabcd".
REQ-035 Overlap: after 'x', token (pos=0,len=5,'y') -> "xxxxxy"; history holds 6 new symbols.
REQ-036 Backpressure: during COPY toggle out_ready 1,0,0,1 -> out_data held stable while stalled, no symbols lost or repeated, token_ready=0 throughout.
REQ-037 Wrap: emit 2046 literals, then token (pos=3,len=6,'z') -> pointers wrap past 2047 to 0, output equals last 4 literals followed by the first 2 copied ones, then 'z'.
REQ-038 Reset mid-COPY of a len=10 token after 4 symbols -> out_valid=0 immediately, token_ready=1 after release, next literal token output correct with wr_ptr restarted at 0.
